// File: rtl/wait_mask_profiler_pkg.sv
// Shared definitions for the per-core wait-mask profiler: wait-source ordering
// and the saturating increment used by every counter.
package wait_mon_pkg;

    typedef enum int {
        SRC_LDMISS   = 0,
        SRC_FP_BUSY  = 1,
        SRC_DIV_BUSY = 2,
        SRC_MUL_BUSY = 3,
        SRC_FP_WAIT  = 4,
        SRC_DIV_WAIT = 5,
        SRC_MUL_WAIT = 6,
        SRC_STBWAIT  = 7,
        SRC_WM_OTHER = 8,
        SRC_WM_IMISS = 9
    } wait_src_e;

    localparam int WM_NUM_SRC = int'(SRC_WM_IMISS) + 1;

    // Callers cast to their own width; maxv is the saturation ceiling.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] maxv);
        return (v >= maxv) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/wait_mask_profiler_if.sv
// Counter readout port: one request per cycle, data returned one cycle later.
interface wait_mask_profiler_if #(
    parameter int NUM_THR = 4,
    parameter int NUM_SRC = 10,
    parameter int CNT_W   = 32
);
    localparam int THR_W = (NUM_THR > 1) ? $clog2(NUM_THR) : 1;
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic             rd_req;
    logic [THR_W-1:0] rd_thr;
    logic [SRC_W-1:0] rd_src;
    logic             rd_vld;
    logic [CNT_W-1:0] rd_data;

    modport master (output rd_req, rd_thr, rd_src, input rd_vld, rd_data);
    modport slave  (input rd_req, rd_thr, rd_src, output rd_vld, rd_data);

endinterface

// File: rtl/wait_mask_profiler_thr.sv
// Per-thread stall bookkeeping: one saturating counter per wait source, a
// continuous-stall run length and the hang watchdog pulse/sticky flags.
module wait_mon_thr
    import wait_mon_pkg::*;
#(
    parameter int NUM_SRC     = 10,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mon_en,
    input  logic                            cnt_clr,
    input  logic [NUM_SRC-1:0]              wait_bits,
    output logic [NUM_SRC-1:0][CNT_W-1:0]   cnt,
    output logic                            hang_pulse,
    output logic                            hang_sticky
);
    localparam int               RUN_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_LIMIT);
    localparam logic [RUN_W-1:0] RUN_PRE   = RUN_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [RUN_W-1:0] run_reg, run_next;
    logic             hang_pulse_reg, hang_sticky_reg;
    logic             stalled, hang_hit;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || cnt_clr)
                    cnt_reg <= '0;
                else if (mon_en && wait_bits[gi])
                    cnt_reg <= CNT_W'(sat_inc(64'(cnt_reg), 64'(CNT_MAX)));
            end
            assign cnt[gi] = cnt_reg;
        end
    endgenerate

    assign stalled  = |wait_bits;
    // The watchdog fires only on the LIMIT-1 -> LIMIT step; run saturates
    // at LIMIT, so it cannot refire until the run has restarted from 0.
    assign hang_hit = stalled && (run_reg == RUN_PRE);

    always_comb begin
        run_next = '0;
        if (stalled)
            run_next = RUN_W'(sat_inc(64'(run_reg), 64'(RUN_LIMIT)));
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            run_reg         <= '0;
            hang_pulse_reg  <= 1'b0;
            hang_sticky_reg <= 1'b0;
        end else if (mon_en) begin
            run_reg        <= run_next;
            hang_pulse_reg <= hang_hit;
            if (hang_hit)
                hang_sticky_reg <= 1'b1;
        end else begin
            hang_pulse_reg <= 1'b0;
        end
    end

    assign hang_pulse  = hang_pulse_reg;
    assign hang_sticky = hang_sticky_reg;

endmodule

// File: rtl/wait_mask_profiler.sv
// Per-core thread-stall monitor: per-thread counters, mask change counting and
// trace strobe, plus a registered counter readout mux.
module wait_mask_profiler
    import wait_mon_pkg::*;
#(
    parameter int NUM_THR     = 4,
    parameter int NUM_SRC     = WM_NUM_SRC,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 4096,
    parameter int TRACE_EN    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mon_en,
    input  logic [9:0]                 coreid,
    input  logic [NUM_SRC*NUM_THR-1:0] wait_vec,
    input  logic                       cnt_clr,
    wait_mask_profiler_if.slave        rd,
    output logic [NUM_THR-1:0]         hang_pulse,
    output logic [NUM_THR-1:0]         hang_sticky,
    output logic [CNT_W-1:0]           chg_cnt,
    output logic                       trace_vld,
    output logic [9:0]                 trace_core
);
    localparam int               THR_W   = (NUM_THR > 1) ? $clog2(NUM_THR) : 1;
    localparam int               SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_SRC-1:0]            thr_bits [NUM_THR];
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_all  [NUM_THR];
    logic [CNT_W-1:0]              rd_tab   [2**THR_W][2**SRC_W];

    logic [NUM_SRC*NUM_THR-1:0] prev_reg;
    logic [CNT_W-1:0]           chg_cnt_reg;
    logic                       rd_vld_reg;
    logic [CNT_W-1:0]           rd_data_reg;
    logic                       chg;

    generate
        for (genvar gi = 0; gi < NUM_THR; gi++) begin : g_thr
            for (genvar gj = 0; gj < NUM_SRC; gj++) begin : g_bit
                assign thr_bits[gi][gj] = wait_vec[gj*NUM_THR + gi];
            end
            wait_mon_thr #(
                .NUM_SRC     (NUM_SRC),
                .CNT_W       (CNT_W),
                .STALL_LIMIT (STALL_LIMIT)
            ) u_thr (
                .clk         (clk),
                .rst         (rst),
                .mon_en      (mon_en),
                .cnt_clr     (cnt_clr),
                .wait_bits   (thr_bits[gi]),
                .cnt         (cnt_all[gi]),
                .hang_pulse  (hang_pulse[gi]),
                .hang_sticky (hang_sticky[gi])
            );
        end

        // Padded to the full index space so out-of-range reads return zero.
        for (genvar gi = 0; gi < 2**THR_W; gi++) begin : g_rd_thr
            for (genvar gj = 0; gj < 2**SRC_W; gj++) begin : g_rd_src
                if (gi < NUM_THR && gj < NUM_SRC) begin : g_hit
                    assign rd_tab[gi][gj] = cnt_all[gi][gj];
                end else begin : g_miss
                    assign rd_tab[gi][gj] = '0;
                end
            end
        end
    endgenerate

    assign chg = (wait_vec != prev_reg);

    // prev survives cnt_clr so the next change is still measured correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg    <= '0;
            chg_cnt_reg <= '0;
        end else begin
            if (mon_en)
                prev_reg <= wait_vec;
            if (cnt_clr)
                chg_cnt_reg <= '0;
            else if (mon_en && chg)
                chg_cnt_reg <= CNT_W'(sat_inc(64'(chg_cnt_reg), 64'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_reg  <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            rd_vld_reg <= rd.rd_req;
            if (rd.rd_req)
                rd_data_reg <= rd_tab[rd.rd_thr][rd.rd_src];
        end
    end

    assign rd.rd_vld   = rd_vld_reg;
    assign rd.rd_data  = rd_data_reg;
    assign chg_cnt     = chg_cnt_reg;
    assign trace_vld   = (TRACE_EN != 0) && mon_en && !rst && chg;
    assign trace_core  = coreid;

endmodule

// File: tb/tb_wait_mask_profiler.sv
// Directed bench for wait_mask_profiler: reads are scoreboarded through a queue
// and checked by a separate monitor; flags and chg_cnt are checked inline.
module tb_wait_mask_profiler;
    import wait_mon_pkg::*;

    localparam int NT = 4;
    localparam int NS = 10;
    localparam int CW = 4;
    localparam int SL = 8;

    logic           clk = 1'b0;
    logic           rst, mon_en, cnt_clr;
    logic [9:0]     coreid;
    logic [NS*NT-1:0] wait_vec;
    logic [NT-1:0]  hang_pulse, hang_sticky;
    logic [CW-1:0]  chg_cnt;
    logic           trace_vld;
    logic [9:0]     trace_core;

    wait_mask_profiler_if #(.NUM_THR(NT), .NUM_SRC(NS), .CNT_W(CW)) rif();

    wait_mask_profiler #(
        .NUM_THR(NT), .NUM_SRC(NS), .CNT_W(CW), .STALL_LIMIT(SL), .TRACE_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .mon_en(mon_en), .coreid(coreid), .wait_vec(wait_vec),
        .cnt_clr(cnt_clr), .rd(rif), .hang_pulse(hang_pulse), .hang_sticky(hang_sticky),
        .chg_cnt(chg_cnt), .trace_vld(trace_vld), .trace_core(trace_core)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int trace_cnt = 0;
    logic [CW-1:0] exp_q[$];
    string         name_q[$];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(int t, int s, int exp, string nm);
        rif.rd_req = 1'b1;
        rif.rd_thr = 2'(t);
        rif.rd_src = 4'(s);
        exp_q.push_back(CW'(exp));
        name_q.push_back(nm);
        step(1);
        rif.rd_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_vec = '0;
        rif.rd_req = 1'b1;
        rif.rd_thr = 2'd1;
        rif.rd_src = 4'd0;
        step(2);
        rst = 1'b0;
        rif.rd_req = 1'b0;
        check("rst_drops_read", 64'(rif.rd_vld), 64'd0);
        check("rst_sticky", 64'(hang_sticky), 64'd0);
        check("rst_chg_cnt", 64'(chg_cnt), 64'd0);
    endtask

    // Read-response monitor: each valid beat consumes one scoreboard entry.
    initial begin
        logic [CW-1:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (rif.rd_vld === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rd_vld: got data %0h, expected no response", rif.rd_data);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (rif.rd_data === e) n_pass++;
                    else $display("FAIL %s: got %0h, expected %0h", nm, rif.rd_data, e);
                end
            end
            if (trace_vld === 1'b1) begin
                trace_cnt++;
                $display("%0t: C%0d: WM: %x", $time, trace_core, wait_vec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int tc0, np, pat, npo, npz;
        rst = 1'b1; mon_en = 1'b0; cnt_clr = 1'b0; coreid = 10'd7; wait_vec = '0;
        rif.rd_req = 1'b0; rif.rd_thr = '0; rif.rd_src = '0;

        // 1: reset state and read latency
        step(3);
        rst = 1'b0;
        mon_en = 1'b1;
        check("t1_rd_vld", 64'(rif.rd_vld), 64'd0);
        check("t1_rd_data", 64'(rif.rd_data), 64'd0);
        check("t1_hang_pulse", 64'(hang_pulse), 64'd0);
        check("t1_hang_sticky", 64'(hang_sticky), 64'd0);
        check("t1_chg_cnt", 64'(chg_cnt), 64'd0);
        rd(0, 0, 0, "t1_rd00");
        check("t1_latency", 64'(rif.rd_vld), 64'd1);
        step(1);
        check("t1_vld_drop", 64'(rif.rd_vld), 64'd0);

        // 2: thread1 LDMISS for 10 cycles
        tc0 = trace_cnt;
        wait_vec[SRC_LDMISS*NT + 1] = 1'b1;
        step(10);
        wait_vec = '0;
        step(1);
        check("t2_chg_cnt", 64'(chg_cnt), 64'd2);
        check("t2_trace_lines", 64'(trace_cnt - tc0), 64'd2);
        check("t2_sticky", 64'(hang_sticky), 64'b0010);
        rd(0, 0, 0, "t2_rd00");
        rd(2, 0, 0, "t2_rd20");
        rd(1, 1, 0, "t2_rd11");
        rd(1, 0, 10, "t2_rd10");
        step(1);
        check("t2_vld_idle", 64'(rif.rd_vld), 64'd0);
        check("t2_data_hold", 64'(rif.rd_data), 64'd10);

        // 3: 4-bit counter saturates at 15
        do_reset();
        wait_vec[SRC_DIV_BUSY*NT + 0] = 1'b1;
        step(20);
        wait_vec = '0;
        step(1);
        rd(0, 2, 15, "t3_saturate");
        check("t3_chg_cnt", 64'(chg_cnt), 64'd2);

        // 4: watchdog with STALL_LIMIT=8
        do_reset();
        wait_vec[SRC_LDMISS*NT + 2] = 1'b1;
        np = 0; pat = 0; npo = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (hang_pulse[2]) begin np++; pat = i; end
            if ((hang_pulse & 4'b1011) != 0) npo++;
        end
        check("t4_pulse_cnt", 64'(np), 64'd1);
        check("t4_pulse_cycle", 64'(pat), 64'd8);
        check("t4_other_pulses", 64'(npo), 64'd0);
        check("t4_sticky", 64'(hang_sticky), 64'b0100);
        wait_vec = '0;
        step(1);
        check("t4_pulse_after_drop", 64'(hang_pulse), 64'd0);
        wait_vec[SRC_MUL_WAIT*NT + 2] = 1'b1;
        np = 0; pat = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (hang_pulse[2]) begin np++; pat = i; end
        end
        check("t4_pulse2_cnt", 64'(np), 64'd1);
        check("t4_pulse2_cycle", 64'(pat), 64'd8);
        check("t4_sticky2", 64'(hang_sticky), 64'b0100);

        // 5: clear beats increment; same-cycle read sees pre-clear value
        do_reset();
        wait_vec[SRC_FP_WAIT*NT + 0] = 1'b1;
        step(4);
        wait_vec[SRC_FP_BUSY*NT + 3] = 1'b1;
        step(5);
        check("t5_sticky_pre", 64'(hang_sticky), 64'b0001);
        cnt_clr = 1'b1;
        rd(3, 1, 5, "t5_pre_clr");
        cnt_clr = 1'b0;
        wait_vec = '0;
        check("t5_sticky_clr", 64'(hang_sticky), 64'd0);
        check("t5_chg_clr", 64'(chg_cnt), 64'd0);
        rd(3, 1, 0, "t5_post_clr");
        check("t5_prev_kept", 64'(chg_cnt), 64'd1);
        rd(0, 4, 0, "t5_rd04");

        // 6: freeze with mon_en=0, then streamed reads
        tc0 = trace_cnt;
        wait_vec[SRC_LDMISS*NT + 0] = 1'b1;
        step(3);
        check("t6_trace_en", 64'(trace_cnt - tc0), 64'd1);
        check("t6_chg_pre", 64'(chg_cnt), 64'd2);
        mon_en = 1'b0;
        tc0 = trace_cnt;
        npz = 0;
        for (int i = 0; i < 5; i++) begin
            wait_vec = 40'(i * 37 + 5) | (40'(i) << 20);
            step(1);
            if (hang_pulse != 0) npz++;
        end
        check("t6_no_pulse", 64'(npz), 64'd0);
        check("t6_no_trace", 64'(trace_cnt - tc0), 64'd0);
        check("t6_chg_frozen", 64'(chg_cnt), 64'd2);
        rd(0, 0, 3, "t6_rd00");
        rd(0, 1, 0, "t6_rd01");
        rd(1, 12, 0, "t6_oob");
        rd(0, 0, 3, "t6_rd00_again");
        step(2);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
